// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  typedef enum logic {OWN_IF, OWN_LSU} arb_owner_t;

  // The requester that did not own the port last time wins a tie.
  function automatic arb_owner_t other_owner(input arb_owner_t o);
    return (o == OWN_IF) ? OWN_LSU : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick between IF (bit 0) and LSU (bit 1).
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  arb_owner_t last_owner_i,
  output logic [1:0] gnt_o,
  output arb_owner_t winner_o
);

  logic any_req_c;

  assign any_req_c = |req_i;

  always_comb begin
    winner_o = OWN_IF;
    case (req_i)
      2'b01:   winner_o = OWN_IF;
      2'b10:   winner_o = OWN_LSU;
      2'b11:   winner_o = other_owner(last_owner_i);
      default: winner_o = OWN_IF;
    endcase
  end

  assign gnt_o = {any_req_c && (winner_o == OWN_LSU),
                  any_req_c && (winner_o == OWN_IF)};

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store,
// tracking the single outstanding access and steering its completion back.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_LATENCY   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      if_req_i,
  input  logic [ADDRESS_WIDTH-1:0]  if_addr_i,
  output logic                      if_gnt_o,
  output logic                      if_rvalid_o,
  output logic [DATA_WIDTH-1:0]     if_rdata_o,
  input  logic                      lsu_req_i,
  input  logic                      lsu_we_i,
  input  logic [DATA_WIDTH/8-1:0]   lsu_be_i,
  input  logic [ADDRESS_WIDTH-1:0]  lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]     lsu_wdata_i,
  output logic                      lsu_gnt_o,
  output logic                      lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]     lsu_rdata_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, owner_d;
  arb_owner_t       last_owner_q, last_owner_d;
  arb_owner_t       winner;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [1:0]       req_vec;
  logic [1:0]       gnt_vec;
  logic             done_c;
  logic             arb_en_c;
  logic             grant_c;

  // Arbitration window: idle, or the completion cycle of the current access.
  assign done_c   = (state_q == ARB_BUSY) && (lat_cnt_q == CNT_W'(1));
  assign arb_en_c = !rst_i && ((state_q == ARB_IDLE) || done_c);
  assign req_vec  = arb_en_c ? {lsu_req_i, if_req_i} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req_i        (req_vec),
    .last_owner_i (last_owner_q),
    .gnt_o        (gnt_vec),
    .winner_o     (winner)
  );

  assign grant_c = |gnt_vec;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    lat_cnt_d    = lat_cnt_q;
    if (state_q == ARB_BUSY) begin
      lat_cnt_d = lat_cnt_q - CNT_W'(1);
      if (done_c) begin
        state_d = ARB_IDLE;
      end
    end
    // A grant in the completion cycle overrides the return to idle.
    if (grant_c) begin
      state_d      = ARB_BUSY;
      owner_d      = winner;
      last_owner_d = winner;
      lat_cnt_d    = CNT_W'(MEM_LATENCY);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      lat_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      lat_cnt_q    <= lat_cnt_d;
    end
  end

  // Request side: memory fields follow the winner and are zero when idle.
  always_comb begin
    if_gnt_o    = gnt_vec[0];
    lsu_gnt_o   = gnt_vec[1];
    mem_req_o   = grant_c;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (grant_c) begin
      if (winner == OWN_LSU) begin
        mem_we_o    = lsu_we_i;
        mem_be_o    = lsu_be_i;
        mem_addr_o  = lsu_addr_i;
        mem_wdata_o = lsu_wdata_i;
      end else begin
        mem_be_o    = '1;
        mem_addr_o  = if_addr_i;
      end
    end
  end

  // Completion side: only the owner sees rvalid and the returned word.
  always_comb begin
    if_rvalid_o  = 1'b0;
    if_rdata_o   = '0;
    lsu_rvalid_o = 1'b0;
    lsu_rdata_o  = '0;
    if (done_c) begin
      if (owner_q == OWN_IF) begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = mem_rdata_i;
      end else begin
        lsu_rvalid_o = 1'b1;
        lsu_rdata_o  = mem_rdata_i;
      end
    end
  end

endmodule
